// File: rtl/motor_ctrl_pkg.sv
// Purpose: shared state encoding and width helpers for the motor controller FSM.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package motor_ctrl_pkg;

    // Controller states, 3-bit encoding; codes 6 and 7 are unreachable.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FPULSE = 3'd1,
        S_SEARCH = 3'd2,
        S_GWAIT  = 3'd3,
        S_PASS   = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // True when pat has no bits set at or above position len.
    function automatic bit pattern_fits(input logic [31:0] pat, input int len);
        return (len >= 32) ? 1'b1 : ((pat >> len) == 32'd0);
    endfunction

endpackage

// File: rtl/seq_matcher.sv
// Purpose: serial pattern detector; shifts x into a history and flags a full-length match.
// Latency: match is combinational on the bit being sampled this cycle.
// Backpressure: none; x is consumed every cycle en is high.
module seq_matcher
    import motor_ctrl_pkg::*;
#(
    parameter int          PAT_LEN = 3,
    parameter logic [31:0] PATTERN = 32'b101
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic match
);

    localparam int                 HCW     = cnt_width(PAT_LEN);
    localparam logic [HCW-1:0]     HC_FULL = HCW'(PAT_LEN);
    localparam logic [HCW-1:0]     HC_NEAR = HCW'(PAT_LEN - 1);
    localparam logic [PAT_LEN-1:0] PAT     = PATTERN[PAT_LEN-1:0];

    logic [PAT_LEN-1:0] r_hist;
    logic [HCW-1:0]     r_hcnt;
    logic [PAT_LEN-1:0] w_hist_next;

    // History as it will be after this cycle's bit is shifted in (MSB = oldest).
    generate
        if (PAT_LEN == 1) begin : g_single
            assign w_hist_next = x;
        end else begin : g_multi
            assign w_hist_next = {r_hist[PAT_LEN-2:0], x};
        end
    endgenerate

    // A match needs a full window of bits gathered since the last clear.
    assign match = en & (r_hcnt >= HC_NEAR) & (w_hist_next == PAT);

    // History and saturating bit count; clr discards anything seen before.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hist <= '0;
            r_hcnt <= '0;
        end else if (clr) begin
            r_hist <= '0;
            r_hcnt <= '0;
        end else if (en) begin
            r_hist <= w_hist_next;
            if (r_hcnt != HC_FULL) begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/motor_ctrl_fsm_param.sv
// Purpose: start pulse, serial pattern search, timed y response, sticky pass/fail.
// Latency: g rises the cycle after the last pattern bit; pass/fail the cycle after y/timeout.
// Backpressure: none; x, y and rearm are sampled every cycle, rearm wins over everything.
module motor_ctrl_fsm_param
    import motor_ctrl_pkg::*;
#(
    parameter int          PAT_LEN  = 3,
    parameter logic [31:0] PATTERN  = 32'b101,
    parameter int          Y_WINDOW = 2,
    parameter int          F_CYCLES = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic x,
    input  logic y,
    input  logic rearm,
    output logic f,
    output logic g,
    output logic pass,
    output logic fail,
    output logic busy
);

    localparam int             FCW    = cnt_width(F_CYCLES);
    localparam int             WCW    = cnt_width(Y_WINDOW);
    localparam logic [FCW-1:0] F_LAST = FCW'(F_CYCLES - 1);
    localparam logic [WCW-1:0] W_LAST = WCW'(Y_WINDOW - 1);

    // Reject parameter sets the datapath cannot represent.
    generate
        if (PAT_LEN < 1 || PAT_LEN > 16) begin : g_bad_len
            $error("motor_ctrl_fsm_param: PAT_LEN must be in 1..16");
        end
        if (Y_WINDOW < 1 || F_CYCLES < 1) begin : g_bad_cnt
            $error("motor_ctrl_fsm_param: Y_WINDOW and F_CYCLES must be >= 1");
        end
        if (!pattern_fits(PATTERN, PAT_LEN)) begin : g_bad_pat
            $error("motor_ctrl_fsm_param: PATTERN wider than PAT_LEN");
        end
    endgenerate

    state_t         r_state;
    state_t         w_state_nxt;
    logic [FCW-1:0] r_fcnt;
    logic [WCW-1:0] r_wcnt;
    logic           w_match;
    logic           w_clr;
    logic           w_en;

    seq_matcher #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_matcher (
        .clk    (clk),
        .resetn (resetn),
        .clr    (w_clr),
        .en     (w_en),
        .x      (x),
        .match  (w_match)
    );

    // State register; reset lands in IDLE without waiting for a clock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pulse and window counters run only in their own state and sit at zero otherwise,
    // so each state is always entered with a fresh count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fcnt <= '0;
            r_wcnt <= '0;
        end else begin
            r_fcnt <= (r_state == S_FPULSE) ? r_fcnt + 1'b1 : '0;
            r_wcnt <= (r_state == S_GWAIT)  ? r_wcnt + 1'b1 : '0;
        end
    end

    // Next-state selection and Moore output decode of the registered state.
    always_comb begin
        w_state_nxt = r_state;
        f           = 1'b0;
        g           = 1'b0;
        pass        = 1'b0;
        fail        = 1'b0;
        busy        = 1'b0;
        w_en        = 1'b0;
        w_clr       = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FPULSE;
            end
            S_FPULSE: begin
                f    = 1'b1;
                busy = 1'b1;
                if (r_fcnt == F_LAST) begin
                    w_state_nxt = S_SEARCH;
                end
            end
            S_SEARCH: begin
                busy  = 1'b1;
                w_en  = 1'b1;
                w_clr = 1'b0;
                if (w_match) begin
                    w_state_nxt = S_GWAIT;
                end
            end
            S_GWAIT: begin
                g    = 1'b1;
                busy = 1'b1;
                if (y) begin
                    w_state_nxt = S_PASS;
                end else if (r_wcnt == W_LAST) begin
                    w_state_nxt = S_FAIL;
                end
            end
            S_PASS: begin
                g    = 1'b1;
                pass = 1'b1;
            end
            S_FAIL: begin
                fail = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (rearm) begin
            w_state_nxt = S_IDLE;
        end
    end

endmodule

// File: tb/tb_motor_ctrl_fsm_param.sv
// Purpose: checks two parameterisations of the motor controller against a timeline model.
// Latency: outputs compared at every falling edge after the model has seen the rising edge.
// Backpressure: n/a.
module tb_motor_ctrl_fsm_param;

    localparam int          A_LEN = 3;
    localparam logic [31:0] A_PAT = 32'b101;
    localparam int          A_WIN = 2;
    localparam int          A_F   = 1;
    localparam int          B_LEN = 4;
    localparam logic [31:0] B_PAT = 32'b1101;
    localparam int          B_WIN = 4;
    localparam int          B_F   = 3;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic xa = 1'b0, ya = 1'b0, ra = 1'b0;
    logic xb = 1'b0, yb = 1'b0, rb = 1'b0;
    logic fa, ga, pa, fla, ba;
    logic fb, gb, pb, flb, bb;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: t = cycles since (re)start, bits seen while searching, cycle g first rose,
    // outcome (0 pending, 1 pass, 2 fail).
    int m_t     [2];
    int m_grant [2];
    int m_res   [2];
    int m_n     [2];
    bit m_bits  [2][4096];

    always #5 clk = ~clk;

    motor_ctrl_fsm_param #(
        .PAT_LEN(A_LEN), .PATTERN(A_PAT), .Y_WINDOW(A_WIN), .F_CYCLES(A_F)
    ) dut_a (
        .clk(clk), .resetn(resetn), .x(xa), .y(ya), .rearm(ra),
        .f(fa), .g(ga), .pass(pa), .fail(fla), .busy(ba)
    );

    motor_ctrl_fsm_param #(
        .PAT_LEN(B_LEN), .PATTERN(B_PAT), .Y_WINDOW(B_WIN), .F_CYCLES(B_F)
    ) dut_b (
        .clk(clk), .resetn(resetn), .x(xb), .y(yb), .rearm(rb),
        .f(fb), .g(gb), .pass(pb), .fail(flb), .busy(bb)
    );

    function automatic int plen(input int d); return (d == 0) ? A_LEN : B_LEN; endfunction
    function automatic int ppat(input int d); return (d == 0) ? int'(A_PAT) : int'(B_PAT); endfunction
    function automatic int pwin(input int d); return (d == 0) ? A_WIN : B_WIN; endfunction
    function automatic int pfc (input int d); return (d == 0) ? A_F : B_F; endfunction

    function automatic logic [4:0] va(); return {fa, ga, pa, fla, ba}; endfunction
    function automatic logic [4:0] vb(); return {fb, gb, pb, flb, bb}; endfunction

    task automatic model_clear(input int d);
        m_t[d] = 0; m_grant[d] = -1; m_res[d] = 0; m_n[d] = 0;
    endtask

    function automatic bit pattern_hit(input int d);
        int v;
        if (m_n[d] < plen(d)) return 1'b0;
        v = 0;
        for (int i = 0; i < plen(d); i++) begin
            v = (v << 1) | int'(m_bits[d][(m_n[d] - plen(d) + i) % 4096]);
        end
        return v == ppat(d);
    endfunction

    task automatic model_step(input int d, input logic xv, input logic yv, input logic rv);
        if (rv) begin
            model_clear(d);
        end else begin
            if (m_res[d] == 0) begin
                if (m_grant[d] < 0) begin
                    if (m_t[d] > pfc(d)) begin
                        m_bits[d][m_n[d] % 4096] = xv;
                        m_n[d]++;
                        if (pattern_hit(d)) m_grant[d] = m_t[d] + 1;
                    end
                end else if (yv) begin
                    m_res[d] = 1;
                end else if (m_t[d] - m_grant[d] == pwin(d) - 1) begin
                    m_res[d] = 2;
                end
            end
            if (m_t[d] < 1000000) m_t[d]++;
        end
    endtask

    function automatic logic [4:0] exp_vec(input int d);
        logic fe, ge, pe, fle, be;
        fe  = (m_t[d] >= 1) && (m_t[d] <= pfc(d));
        ge  = (m_grant[d] >= 0) && (m_res[d] != 2);
        pe  = (m_res[d] == 1);
        fle = (m_res[d] == 2);
        be  = (m_t[d] >= 1) && (m_res[d] == 0);
        return {fe, ge, pe, fle, be};
    endfunction

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed {f,g,pass,fail,busy}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_models();
        chk("model_a", va(), exp_vec(0));
        chk("model_b", vb(), exp_vec(1));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!resetn) begin
            model_clear(0);
            model_clear(1);
        end else begin
            model_step(0, xa, ya, ra);
            model_step(1, xb, yb, rb);
        end
        @(negedge clk);
        check_models();
    endtask

    initial begin
        logic [5:0] seq6;
        logic [3:0] seq4;
        model_clear(0);
        model_clear(1);

        // Reset state and release.
        #12;
        chk("rst_a", va(), 5'b00000);
        chk("rst_b", vb(), 5'b00000);
        @(negedge clk);
        resetn = 1'b1;
        check_models();
        chk("a_c1_idle", va(), 5'b00000);
        tick(); chk("a_c2_fpulse", va(), 5'b10001); chk("b_c2_fpulse", vb(), 5'b10001);
        tick(); chk("a_c3_search", va(), 5'b00001); chk("b_c3_fpulse", vb(), 5'b10001);

        // 101 -> g next cycle; y in first window cycle -> sticky PASS.
        xa = 1'b1; tick();
        xa = 1'b0; tick();
        xa = 1'b1; tick(); chk("a_match_101", va(), 5'b01001);
        ya = 1'b1; xa = 1'b0; tick(); chk("a_pass", va(), 5'b01100);
        for (int i = 0; i < 22; i++) begin
            xa = 1'($urandom_range(0, 1));
            ya = 1'($urandom_range(0, 1));
            tick(); chk("a_pass_hold", va(), 5'b01100);
        end

        // Rearm from PASS, overlapping 1101 match, window timeout, late y ignored.
        ya = 1'b0; xa = 1'b0; ra = 1'b1; tick(); chk("a_rearm_pass", va(), 5'b00000);
        ra = 1'b0; tick(); chk("a_refpulse", va(), 5'b10001);
        tick(); chk("a_research", va(), 5'b00001);
        xa = 1'b1; tick();
        xa = 1'b1; tick();
        xa = 1'b0; tick(); chk("a_1101_no_early", va(), 5'b00001);
        xa = 1'b1; tick(); chk("a_1101_match", va(), 5'b01001);
        xa = 1'b0; ya = 1'b0; tick(); chk("a_win2", va(), 5'b01001);
        tick(); chk("a_fail", va(), 5'b00010);
        ya = 1'b1; tick(); chk("a_late_y", va(), 5'b00010);
        ya = 1'b0; ra = 1'b1; tick(); chk("a_rearm_fail", va(), 5'b00000);
        ra = 1'b0; tick(); tick();

        // 100100 never matches; partial 10 then rearm leaves no stale history.
        seq6 = 6'b100100;
        for (int i = 5; i >= 0; i--) begin
            xa = seq6[i]; tick(); chk("a_nomatch", va(), 5'b00001);
        end
        xa = 1'b1; tick();
        xa = 1'b0; tick(); chk("a_partial", va(), 5'b00001);
        ra = 1'b1; tick(); chk("a_rearm_search", va(), 5'b00000);
        ra = 1'b0; tick(); chk("a_f_again", va(), 5'b10001);
        tick();
        xa = 1'b1; tick(); chk("a_hist_cleared", va(), 5'b00001);

        // Async reset in the middle of the window.
        xa = 1'b0; tick();
        xa = 1'b1; tick(); chk("a_gwait2", va(), 5'b01001);
        xa = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("async_a", va(), 5'b00000);
        chk("async_b", vb(), 5'b00000);
        model_clear(0);
        model_clear(1);
        @(negedge clk);
        resetn = 1'b1;
        check_models();

        // Second parameter set: 3-cycle f, 1101, 4-cycle window.
        tick(); chk("b_f1", vb(), 5'b10001);
        tick(); chk("b_f2", vb(), 5'b10001);
        tick(); chk("b_f3", vb(), 5'b10001);
        tick(); chk("b_search", vb(), 5'b00001);
        seq4 = 4'b1101;
        for (int i = 3; i >= 0; i--) begin
            xb = seq4[i]; tick();
        end
        chk("b_match", vb(), 5'b01001);
        xb = 1'b0; yb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("b_win", vb(), 5'b01001);
        end
        yb = 1'b1; tick(); chk("b_pass_w4", vb(), 5'b01100);
        yb = 1'b0; rb = 1'b1; tick();
        rb = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 3; i >= 0; i--) begin
            xb = seq4[i]; tick();
        end
        chk("b_match2", vb(), 5'b01001);
        xb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b_timeout", vb(), (i == 3) ? 5'b00010 : 5'b01001);
        end
        yb = 1'b1; tick(); chk("b_late_y", vb(), 5'b00010);

        // Random traffic on both instances, judged by the model alone.
        for (int i = 0; i < 1500; i++) begin
            xa = 1'($urandom_range(0, 1));
            ya = ($urandom_range(0, 3) == 0);
            ra = ($urandom_range(0, 63) == 0);
            xb = 1'($urandom_range(0, 1));
            yb = ($urandom_range(0, 4) == 0);
            rb = ($urandom_range(0, 47) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
